mix_columns_iter: RTL and testbench

Iterative, parametrised AES MixColumns / InvMixColumns engine operating on a full 128-bit state with valid/ready handshakes on both sides. It generalises the single-row GF(2^8) multiply-and-reduce function to all four rows and all four columns, adds an inverse mode, and time-multiplexes the column datapath under a width parameter. It sits between ShiftRows and AddRoundKey in the round pipeline.

---
 rtl/mix_columns_iter.sv | 125 ++++++++++++
 tb/tb_mix_columns_iter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mix_columns_iter.sv
// rtl/mix_columns_iter.sv - iterative AES MixColumns/InvMixColumns engine with valid/ready handshakes
// Transforms COLS_PER_CYCLE columns of the working register in place per BUSY cycle.
module mix_columns_iter #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         out_inv
);

  localparam int C     = COLS_PER_CYCLE;
  localparam int N     = 4 / C;
  localparam int CNT_W = (N <= 2) ? 1 : $clog2(N);

  if ((C != 1) && (C != 2) && (C != 4)) begin : g_bad_cols
    $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             fsm_q, fsm_d;
  logic [127:0]       state_q, state_d;
  logic               inv_q, inv_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
    logic [7:0] a  [4];
    logic [7:0] m2 [4];
    logic [7:0] m3 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x4, x8;
    logic [31:0] res;
    for (int r = 0; r < 4; r++) begin
      a[r]  = col[31-8*r -: 8];
      m2[r] = xt(a[r]);
      x4    = xt(m2[r]);
      x8    = xt(x4);
      m3[r] = m2[r] ^ a[r];
      m9[r] = x8 ^ a[r];
      mb[r] = x8 ^ m2[r] ^ a[r];
      md[r] = x8 ^ x4 ^ a[r];
      me[r] = x8 ^ x4 ^ m2[r];
    end
    res = '0;
    // Every output row is the first row's coefficients rotated right by r.
    for (int r = 0; r < 4; r++) begin
      if (inv)
        res[31-8*r -: 8] = me[r] ^ mb[(r+1)%4] ^ md[(r+2)%4] ^ m9[(r+3)%4];
      else
        res[31-8*r -: 8] = m2[r] ^ m3[(r+1)%4] ^ a[(r+2)%4] ^ a[(r+3)%4];
    end
    return res;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      inv_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      inv_q   <= inv_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    fsm_d     = fsm_q;
    state_d   = state_q;
    inv_d     = inv_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (fsm_q)
      IDLE: begin
        in_ready = 1'b1;
      end
      BUSY: begin
        for (int g = 0; g < C; g++) begin
          state_d[127-32*(int'(cnt_q)*C+g) -: 32] =
            mix_col(state_q[127-32*(int'(cnt_q)*C+g) -: 32], inv_q);
        end
        if (cnt_q == CNT_W'(N-1)) begin
          cnt_d = '0;
          fsm_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
    // Accept covers both the idle load and the drain-and-accept from DONE.
    if (in_ready && in_valid) begin
      state_d = in_state;
      inv_d   = in_inv;
      cnt_d   = '0;
      fsm_d   = BUSY;
    end
  end

  assign out_state = state_q;
  assign out_inv   = inv_q;

endmodule

// File: tb/tb_mix_columns_iter.sv
// tb/tb_mix_columns_iter.sv - directed bench for mix_columns_iter with C=1, 2 and 4 instances
module tb_mix_columns_iter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid [3];
  logic         in_ready [3];
  logic [127:0] in_state;
  logic         in_inv;
  logic         out_valid [3];
  logic         out_ready [3];
  logic [127:0] out_state [3];
  logic         out_inv [3];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mix_columns_iter #(.COLS_PER_CYCLE(1)) u_c1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_state(in_state), .in_inv(in_inv), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_state(out_state[0]), .out_inv(out_inv[0]));
  mix_columns_iter #(.COLS_PER_CYCLE(2)) u_c2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_state(in_state), .in_inv(in_inv), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_state(out_state[1]), .out_inv(out_inv[1]));
  mix_columns_iter #(.COLS_PER_CYCLE(4)) u_c4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_state(in_state), .in_inv(in_inv), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .out_state(out_state[2]), .out_inv(out_inv[2]));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full transaction on instance k; mode and data are scrambled during BUSY.
  task automatic xfer(input int k, input logic [127:0] st, input logic inv,
                      output logic [127:0] res, output logic rinv, output int lat);
    int t;
    @(negedge clk);
    in_state = st;
    in_inv = inv;
    in_valid[k] = 1'b1;
    t = 0;
    while (!in_ready[k] && t < 50) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid[k] = 1'b0;
    in_inv = ~inv;
    in_state = {$urandom, $urandom, $urandom, $urandom};
    lat = 0;
    while (!out_valid[k] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    res = out_state[k];
    rinv = out_inv[k];
    out_ready[k] = 1'b1;
    @(negedge clk);
    out_ready[k] = 1'b0;
  endtask

  localparam logic [127:0] KAT_IN  = 128'hdb135345_f20a225c_d4bf5d30_c6c6c6c6;
  localparam logic [127:0] KAT_OUT = 128'h8e4da1bc_9fdc589d_046681e5_c6c6c6c6;

  logic [31:0]  col_in  [5] = '{32'hdb135345, 32'hf20a225c, 32'hd4bf5d30, 32'hc6c6c6c6, 32'h01010101};
  logic [31:0]  col_out [5] = '{32'h8e4da1bc, 32'h9fdc589d, 32'h046681e5, 32'hc6c6c6c6, 32'h01010101};
  logic [127:0] vec [6];
  logic [127:0] vexp [6];
  logic [127:0] res, res2, orig;
  logic         rinv;
  int           lat, ii, oi, cyc, last;
  logic         acc_pending;

  initial begin
    for (int k = 0; k < 3; k++) begin
      in_valid[k] = 1'b0;
      out_ready[k] = 1'b0;
    end
    in_state = '0;
    in_inv = 1'b0;

    // Reset values
    #12;
    for (int k = 0; k < 3; k++) begin
      chk("rst_in_ready", 128'(in_ready[k]), 128'd1);
      chk("rst_out_valid", 128'(out_valid[k]), 128'd0);
      chk("rst_out_state", out_state[k], 128'd0);
      chk("rst_out_inv", 128'(out_inv[k]), 128'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Forward single-column known answers, column 0 only
    for (int v = 0; v < 4; v++) begin
      xfer(0, {col_in[v], 96'd0}, 1'b0, res, rinv, lat);
      chk("fwd_col", res, {col_out[v], 96'd0});
      chk("fwd_lat", 128'(lat), 128'd4);
      chk("fwd_inv", 128'(rinv), 128'd0);
    end

    // Inverse full-state answer at each width
    for (int k = 0; k < 3; k++) begin
      xfer(k, KAT_OUT, 1'b1, res, rinv, lat);
      chk("inv_state", res, KAT_IN);
      chk("inv_lat", 128'(lat), 128'(4 >> k));
      chk("inv_inv", 128'(rinv), 128'd1);
    end
    xfer(2, KAT_IN, 1'b0, res, rinv, lat);
    chk("fwd_c4_state", res, KAT_OUT);

    // Random round trips across all widths
    for (int i = 0; i < 1000; i++) begin
      orig = {$urandom, $urandom, $urandom, $urandom};
      xfer(i % 3, orig, 1'b0, res, rinv, lat);
      chk("rt_fwd_inv", 128'(rinv), 128'd0);
      xfer(i % 3, res, 1'b1, res2, rinv, lat);
      chk("rt_inv_inv", 128'(rinv), 128'd1);
      chk("rt_identity", res2, orig);
    end

    // Backpressure with a pending input, then drain and accept on one edge
    @(negedge clk);
    in_state = KAT_IN;
    in_inv = 1'b0;
    in_valid[0] = 1'b1;
    @(negedge clk);
    in_state = KAT_OUT;
    in_inv = 1'b1;
    cyc = 0;
    while (!out_valid[0] && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    for (int t = 0; t < 10; t++) begin
      chk("bp_hold_state", out_state[0], KAT_OUT);
      chk("bp_in_ready", 128'(in_ready[0]), 128'd0);
      @(negedge clk);
    end
    out_ready[0] = 1'b1;
    #1;
    chk("bp_ready_comb", 128'(in_ready[0]), 128'd1);
    @(negedge clk);
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b0;
    chk("bp_drained", 128'(out_valid[0]), 128'd0);
    lat = 0;
    while (!out_valid[0] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("bp_next_lat", 128'(lat), 128'd4);
    chk("bp_next_state", out_state[0], KAT_IN);
    chk("bp_next_inv", 128'(out_inv[0]), 128'd1);
    out_ready[0] = 1'b1;
    @(negedge clk);
    out_ready[0] = 1'b0;

    // Back-to-back streaming at C=2
    for (int i = 0; i < 6; i++) begin
      for (int c = 0; c < 4; c++) begin
        vec[i][127-32*c -: 32]  = col_in[(i + c) % 5];
        vexp[i][127-32*c -: 32] = col_out[(i + c) % 5];
      end
    end
    ii = 0; oi = 0; cyc = 0; last = -1; acc_pending = 1'b0;
    in_inv = 1'b0;
    out_ready[1] = 1'b1;
    while (oi < 6 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (acc_pending) ii++;
      if (out_valid[1]) begin
        chk("b2b_state", out_state[1], vexp[oi]);
        if (last >= 0) chk("b2b_gap", 128'(cyc - last), 128'd3);
        last = cyc;
        oi++;
      end
      if (ii < 6) begin
        in_state = vec[ii];
        in_valid[1] = 1'b1;
      end else begin
        in_valid[1] = 1'b0;
      end
      acc_pending = in_valid[1] && in_ready[1];
    end
    chk("b2b_count", 128'(oi), 128'd6);
    chk("b2b_accepted", 128'(ii), 128'd6);
    in_valid[1] = 1'b0;
    @(negedge clk);
    out_ready[1] = 1'b0;

    // Asynchronous reset after the second BUSY cycle
    @(negedge clk);
    in_state = KAT_IN;
    in_inv = 1'b1;
    in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready", 128'(in_ready[0]), 128'd1);
    chk("arst_out_valid", 128'(out_valid[0]), 128'd0);
    chk("arst_out_state", out_state[0], 128'd0);
    chk("arst_out_inv", 128'(out_inv[0]), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    xfer(0, {4{32'h01010101}}, 1'b0, res, rinv, lat);
    chk("post_rst_state", res, {4{32'h01010101}});
    chk("post_rst_lat", 128'(lat), 128'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
